// File: rtl/gray_to_bin_seq_if.sv
// rtl/gray_to_bin_seq_if.sv - Gray word in / binary result out handshake bundle
interface gray_to_bin_seq_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gray_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] bin_out;
    logic             adj_err;
    logic [CNT_W-1:0] err_count;

    modport slave (
        input  in_valid, gray_in, out_ready,
        output in_ready, out_valid, bin_out, adj_err, err_count
    );

    modport master (
        output in_valid, gray_in, out_ready,
        input  in_ready, out_valid, bin_out, adj_err, err_count
    );
endinterface

// File: rtl/gray_to_bin_seq.sv
// rtl/gray_to_bin_seq.sv - serial MSB-first Gray-to-binary decoder with adjacency checking
module gray_to_bin_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    gray_to_bin_seq_if.slave  bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_g;
    logic [WIDTH-1:0]   r_b;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_prev;
    logic               r_have_prev;
    logic               r_err_next;
    logic [WIDTH-1:0]   r_bin;
    logic               r_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_bit;
    logic               w_err;
    logic [WIDTH-1:0]   w_full;
    logic               w_in_ready;
    logic               w_out_valid;

    // r_carry holds the previously resolved (more significant) binary bit; zero before the MSB.
    assign w_bit = r_carry ^ r_g[r_idx];
    assign w_err = r_have_prev && ($countones(bus.gray_in ^ r_prev) != 1);

    always_comb begin
        w_full    = r_b;
        w_full[0] = w_bit;
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                if (r_idx == '0) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_g         <= '0;
            r_b         <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_err_next  <= 1'b0;
            r_bin       <= '0;
            r_adj       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_g         <= bus.gray_in;
                        r_b         <= '0;
                        r_carry     <= 1'b0;
                        r_idx       <= IDX_W'(WIDTH - 1);
                        r_err_next  <= w_err;
                        r_prev      <= bus.gray_in;
                        r_have_prev <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_b[r_idx] <= w_bit;
                    r_carry    <= w_bit;
                    r_idx      <= r_idx - 1'b1;
                    if (r_idx == '0) begin
                        r_bin <= w_full;
                        r_adj <= r_err_next;
                        if (r_err_next && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.bin_out   = r_bin;
    assign bus.adj_err   = r_adj;
    assign bus.err_count = r_cnt;
endmodule
